// File: rtl/neo_pkg.sv
// Shared types and helpers for the WS2812 pixel driver.
// Channel and FSM encodings, frame geometry, wrap-around counter.
package neo_pkg;

    typedef enum logic [1:0] {
        GREEN = 2'd0,
        RED   = 2'd1,
        BLUE  = 2'd2
    } color_e;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } drv_state_e;

    localparam int BITS_PER_PIXEL = 24;

    function automatic int counter(input int value, input int max);
        return (value == max) ? 0 : value + 1;
    endfunction

endpackage

// File: rtl/neo_bit_encoder.sv
// Shapes one WS2812 data bit: high for T0H/T1H cycles, then low.
// bit_done marks the last cycle of the bit period.
module neo_bit_encoder #(
    parameter int BIT_CYCLES = 63,
    parameter int T0H_CYCLES = 18,
    parameter int T1H_CYCLES = 35
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic bit_val,
    output logic neo_data,
    output logic bit_done
);

    localparam int CW = $clog2(BIT_CYCLES);

    logic [CW-1:0] cnt_q;
    logic          val_q;
    logic          active_q;
    logic          data_q;
    int            hi_len;

    always_comb begin
        hi_len = val_q ? T1H_CYCLES : T0H_CYCLES;
    end

    assign bit_done = active_q && (int'(cnt_q) == BIT_CYCLES - 1);
    assign neo_data = data_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            val_q    <= 1'b0;
            active_q <= 1'b0;
            data_q   <= 1'b0;
        end else if (start) begin
            cnt_q    <= '0;
            val_q    <= bit_val;
            active_q <= 1'b1;
            data_q   <= 1'b1;
        end else if (active_q) begin
            if (bit_done) begin
                cnt_q    <= '0;
                active_q <= 1'b0;
                data_q   <= 1'b0;
            end else begin
                cnt_q  <= cnt_q + 1'b1;
                // Output register leads the counter by one cycle
                data_q <= (int'(cnt_q) + 1) < hi_len;
            end
        end
    end

endmodule

// File: rtl/neopixel_driver.sv
// WS2812 chain driver: GRB frame buffer, serialiser and latch gap.
// Define NEO_DIM_EN to store every level right-shifted by DIM_SHIFT.
module neopixel_driver
    import neo_pkg::*;
#(
    parameter int NUM_PIXELS   = 5,
    parameter int BIT_CYCLES   = 63,
    parameter int T0H_CYCLES   = 18,
    parameter int T1H_CYCLES   = 35,
    parameter int RESET_CYCLES = 2500,
    parameter int DIM_SHIFT    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load_color,
    input  logic [2:0] pixel_index,
    input  logic [1:0] color_index,
    input  logic [7:0] color_level,
    input  logic       send_it,
    output logic       neo_data,
    output logic       ready_to_load,
    output logic       ready_to_send,
    output logic       begin_send,
    output logic       done_send,
    output logic       done_wait
);

`ifdef NEO_DIM_EN
    localparam int DIM_ON = 1;
`else
    localparam int DIM_ON = 0;
`endif

    localparam int SHIFT = DIM_SHIFT * DIM_ON;
    localparam int GW    = $clog2(RESET_CYCLES);

    logic [23:0]   buf_q [NUM_PIXELS];
    logic [23:0]   buf_d [NUM_PIXELS];
    drv_state_e    state_q;
    logic [4:0]    bit_q;
    logic [2:0]    pix_q;
    logic [GW-1:0] gap_q;
    logic          begin_q;

    logic [7:0]    level;
    logic          idle;
    logic          wr_en;
    logic          last_bit;
    logic          gap_end;
    logic [4:0]    nxt_bit;
    logic [2:0]    nxt_pix;
    logic [4:0]    sel_bit;
    logic [2:0]    sel_pix;
    logic [23:0]   pix_word;
    logic          enc_start;
    logic          enc_val;
    logic          bit_done;

    assign level = color_level >> SHIFT;
    assign idle  = (state_q == IDLE);
    assign wr_en = idle && load_color && (color_index != 2'd3)
                   && (int'(pixel_index) < NUM_PIXELS);

    always_comb begin
        buf_d = buf_q;
        if (wr_en) begin
            for (int i = 0; i < NUM_PIXELS; i++) begin
                if (pixel_index == 3'(i)) begin
                    case (color_e'(color_index))
                        GREEN:   buf_d[i][23:16] = level;
                        RED:     buf_d[i][15:8]  = level;
                        BLUE:    buf_d[i][7:0]   = level;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PIXELS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            buf_q <= buf_d;
        end
    end

    assign last_bit = (pix_q == 3'(NUM_PIXELS - 1))
                      && (bit_q == 5'(BITS_PER_PIXEL - 1));
    assign gap_end  = (gap_q == GW'(RESET_CYCLES - 1));
    assign nxt_bit  = 5'(counter(int'(bit_q), BITS_PER_PIXEL - 1));
    assign nxt_pix  = (bit_q == 5'(BITS_PER_PIXEL - 1)) ? pix_q + 3'd1
                                                         : pix_q;

    // Read through buf_d so a write on the send edge lands in the frame
    assign sel_bit   = (idle || last_bit) ? 5'd0 : nxt_bit;
    assign sel_pix   = (idle || last_bit) ? 3'd0 : nxt_pix;
    assign pix_word  = buf_d[sel_pix];
    assign enc_val   = pix_word[5'd23 - sel_bit];
    assign enc_start = (idle && send_it)
                       || ((state_q == SEND) && bit_done && !last_bit);

    neo_bit_encoder #(
        .BIT_CYCLES (BIT_CYCLES),
        .T0H_CYCLES (T0H_CYCLES),
        .T1H_CYCLES (T1H_CYCLES)
    ) u_enc (
        .clock    (clock),
        .reset    (reset),
        .start    (enc_start),
        .bit_val  (enc_val),
        .neo_data (neo_data),
        .bit_done (bit_done)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            pix_q   <= '0;
            gap_q   <= '0;
            begin_q <= 1'b0;
        end else begin
            begin_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (send_it) begin
                        state_q <= SEND;
                        bit_q   <= '0;
                        pix_q   <= '0;
                        begin_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (bit_done) begin
                        if (last_bit) begin
                            state_q <= GAP;
                            gap_q   <= '0;
                        end else begin
                            bit_q <= nxt_bit;
                            pix_q <= nxt_pix;
                        end
                    end
                end
                GAP: begin
                    if (gap_end) begin
                        state_q <= IDLE;
                        gap_q   <= '0;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_to_load = idle;
    assign ready_to_send = idle;
    assign begin_send    = begin_q;
    assign done_send     = (state_q == SEND) && bit_done && last_bit;
    assign done_wait     = (state_q == GAP) && gap_end;

endmodule

// File: tb/tb_neopixel_driver.sv
// Directed bench for neopixel_driver: decodes whole frames bit by bit.
// Honours NEO_DIM_EN when computing expected stored levels.
module tb_neopixel_driver;

    localparam int NP     = 5;
    localparam int BC     = 63;
    localparam int NBITS  = NP * 24;
    localparam int T_DONE = NBITS * BC;
    localparam int T_WAIT = T_DONE + 2500;

    logic       clock;
    logic       reset;
    logic       load_color;
    logic [2:0] pixel_index;
    logic [1:0] color_index;
    logic [7:0] color_level;
    logic       send_it;
    logic       neo_data;
    logic       ready_to_load;
    logic       ready_to_send;
    logic       begin_send;
    logic       done_send;
    logic       done_wait;

    int tests;
    int fails;

    neopixel_driver dut (
        .clock         (clock),
        .reset         (reset),
        .load_color    (load_color),
        .pixel_index   (pixel_index),
        .color_index   (color_index),
        .color_level   (color_level),
        .send_it       (send_it),
        .neo_data      (neo_data),
        .ready_to_load (ready_to_load),
        .ready_to_send (ready_to_send),
        .begin_send    (begin_send),
        .done_send     (done_send),
        .done_wait     (done_wait)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        bit         do_load;
        bit         together;
        bit         interfere;
        logic [2:0] pix;
        logic [1:0] col;
        logic [7:0] lvl;
        bit         hit;
        int         exp_pix;
        int         exp_col;
        logic [7:0] exp_lvl;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] stored(input logic [7:0] l);
`ifdef NEO_DIM_EN
        return l >> 2;
`else
        return l;
`endif
    endfunction

    function automatic logic [NBITS-1:0] mk_frame(input bit hit,
            input int p, input int c, input logic [7:0] l);
        logic [NBITS-1:0] f;
        f = '0;
        if (hit) begin
            for (int j = 0; j < 8; j++) begin
                f[p * 24 + c * 8 + j] = l[7 - j];
            end
        end
        return f;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // Called at a negedge; the send edge is the next posedge.
    task automatic run_frame(input string tag,
            input logic [NBITS-1:0] exp, input bit together,
            input logic [2:0] p, input logic [1:0] c,
            input logic [7:0] l, input bit interfere);
        int hi_cnt [NBITS];
        logic [NBITS-1:0] got;
        int shape_err, bad, beg_err, rdy_err, gap_err;
        int ds_cnt, ds_cyc, dw_cnt, dw_cyc;
        shape_err = 0; bad = 0; beg_err = 0; rdy_err = 0; gap_err = 0;
        ds_cnt = 0; ds_cyc = -1; dw_cnt = 0; dw_cyc = -1;
        got = '0;
        for (int k = 0; k < NBITS; k++) hi_cnt[k] = 0;
        send_it = 1'b1;
        if (together) begin
            load_color  = 1'b1;
            pixel_index = p;
            color_index = c;
            color_level = l;
        end
        @(negedge clock);
        send_it    = 1'b0;
        load_color = 1'b0;
        for (int cy = 1; cy <= T_WAIT + 1; cy++) begin
            if (cy <= T_DONE) begin
                if (neo_data) begin
                    if (hi_cnt[(cy - 1) / BC] != (cy - 1) % BC)
                        shape_err++;
                    hi_cnt[(cy - 1) / BC]++;
                end
            end else if (neo_data) begin
                gap_err++;
            end
            if (begin_send != (cy == 1)) beg_err++;
            if (done_send) begin ds_cnt++; ds_cyc = cy; end
            if (done_wait) begin dw_cnt++; dw_cyc = cy; end
            if (cy <= T_WAIT) begin
                if (ready_to_load || ready_to_send) rdy_err++;
            end else if (!(ready_to_load && ready_to_send)) begin
                rdy_err++;
            end
            if (interfere && (cy == 100 || cy == 8000)) begin
                send_it     = 1'b1;
                load_color  = 1'b1;
                pixel_index = 3'd0;
                color_index = 2'd0;
                color_level = 8'hFF;
            end else begin
                send_it    = 1'b0;
                load_color = 1'b0;
            end
            if (cy <= T_WAIT) @(negedge clock);
        end
        send_it    = 1'b0;
        load_color = 1'b0;
        for (int k = 0; k < NBITS; k++) begin
            if (hi_cnt[k] == 35) got[k] = 1'b1;
            else if (hi_cnt[k] != 18) bad++;
        end
        chk({tag, " frame bits"}, 128'(got), 128'(exp));
        chk({tag, " bad high widths"}, 128'(bad + shape_err), 128'(0));
        chk({tag, " begin_send"}, 128'(beg_err), 128'(0));
        chk({tag, " done_send cycle"}, 128'(ds_cyc), 128'(T_DONE));
        chk({tag, " done_send count"}, 128'(ds_cnt), 128'(1));
        chk({tag, " done_wait cycle"}, 128'(dw_cyc), 128'(T_WAIT));
        chk({tag, " done_wait count"}, 128'(dw_cnt), 128'(1));
        chk({tag, " ready during frame"}, 128'(rdy_err), 128'(0));
        chk({tag, " line low in gap"}, 128'(gap_err), 128'(0));
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        reset       = 1'b1;
        load_color  = 1'b0;
        pixel_index = '0;
        color_index = '0;
        color_level = '0;
        send_it     = 1'b0;

        vecs[0] = '{0, 0, 0, 3'd0, 2'd0, 8'h00, 0, 0, 0, 8'h00};
        vecs[1] = '{1, 0, 0, 3'd0, 2'd0, 8'h80, 1, 0, 0, 8'h80};
        vecs[2] = '{1, 0, 1, 3'd4, 2'd2, 8'h01, 1, 4, 2, 8'h01};
        vecs[3] = '{1, 0, 0, 3'd1, 2'd3, 8'hFF, 0, 0, 0, 8'h00};
        vecs[4] = '{1, 0, 0, 3'd5, 2'd0, 8'hFF, 0, 0, 0, 8'h00};
        vecs[5] = '{1, 1, 0, 3'd2, 2'd1, 8'hFF, 1, 2, 1, 8'hFF};

        @(negedge clock);
        chk("reset ready_to_load", 128'(ready_to_load), 128'(1));
        chk("reset ready_to_send", 128'(ready_to_send), 128'(1));
        chk("reset neo_data", 128'(neo_data), 128'(0));
        chk("reset pulses",
            128'({begin_send, done_send, done_wait}), 128'(0));

        for (int v = 0; v < 6; v++) begin
            do_reset();
            chk($sformatf("v%0d idle ready", v),
                128'({ready_to_load, ready_to_send}), 128'(3));
            if (vecs[v].do_load && !vecs[v].together) begin
                load_color  = 1'b1;
                pixel_index = vecs[v].pix;
                color_index = vecs[v].col;
                color_level = vecs[v].lvl;
                @(negedge clock);
                load_color = 1'b0;
            end
            run_frame($sformatf("v%0d", v),
                mk_frame(vecs[v].hit, vecs[v].exp_pix, vecs[v].exp_col,
                         stored(vecs[v].exp_lvl)),
                vecs[v].together, vecs[v].pix, vecs[v].col,
                vecs[v].lvl, vecs[v].interfere);
        end

        do_reset();
        load_color  = 1'b1;
        pixel_index = 3'd0;
        color_index = 2'd0;
        color_level = 8'hFF;
        @(negedge clock);
        load_color = 1'b0;
        send_it    = 1'b1;
        @(negedge clock);
        send_it = 1'b0;
        repeat (19) @(negedge clock);
        chk("mid-frame high before reset", 128'(neo_data), 128'(1));
        reset = 1'b1;
        #1;
        chk("mid-frame reset neo_data", 128'(neo_data), 128'(0));
        chk("mid-frame reset ready",
            128'({ready_to_load, ready_to_send}), 128'(3));
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("after reset ready",
            128'({ready_to_load, ready_to_send}), 128'(3));
        chk("after reset pulses",
            128'({begin_send, done_send, done_wait, neo_data}), 128'(0));
        run_frame("post-reset", '0, 0, 3'd0, 2'd0, 8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
